// File: rtl/ncr5380_lite.sv
// ncr5380_lite: initiator-side SCSI controller with an NCR 5380 style register view
// and an automatic one-byte-per-access DMA req/ack handshake.
module ncr5380_lite (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_cs,
    input  logic       bus_we,
    input  logic [2:0] bus_addr,
    input  logic       bus_dack,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       drq,
    output logic       irq,
    output logic       scsi_rst,
    output logic       scsi_sel,
    output logic       scsi_atn,
    output logic       scsi_ack,
    output logic [7:0] scsi_dout,
    input  logic       scsi_bsy,
    input  logic       scsi_msg,
    input  logic       scsi_cd,
    input  logic       scsi_io,
    input  logic       scsi_req,
    input  logic [7:0] scsi_din
);
    typedef enum logic [2:0] {IDLE, RX_WAIT_REQ, RX_WAIT_CPU, TX_WAIT_CPU, TX_WAIT_REQ, ACK_HI} state_t;
    state_t state;
    logic ret_tx;
    logic [7:0] odr, icr, mr, dma_data, rd_data;
    logic [2:0] tcr;
    logic dma_ack, end_dma, busy_err;
    logic wr, rd, dwr, drd, phase_match, wait_req, send_active, busy_lost;
    assign wr = bus_cs & bus_we & ~bus_dack;
    assign rd = bus_cs & ~bus_we & ~bus_dack;
    assign dwr = bus_cs & bus_we & bus_dack;
    assign drd = bus_cs & ~bus_we & bus_dack;
    assign phase_match = {scsi_msg, scsi_cd, scsi_io} == tcr;
    assign wait_req = (state == RX_WAIT_REQ) || (state == TX_WAIT_REQ);
    assign send_active = (state == TX_WAIT_CPU) || (state == TX_WAIT_REQ) || (state == ACK_HI && ret_tx);
    assign busy_lost = mr[3] & ~scsi_bsy & (state != IDLE);
    assign scsi_rst = icr[7];
    assign scsi_sel = icr[2];
    assign scsi_atn = icr[1];
    assign scsi_ack = icr[4] | dma_ack;
    assign scsi_dout = (icr[0] | send_active) ? odr : 8'h00;
    always_comb begin
        rd_data = 8'h00;
        case (bus_addr)
            3'd0: rd_data = scsi_io ? scsi_din : scsi_dout;
            3'd1: rd_data = icr;
            3'd2: rd_data = mr;
            3'd3: rd_data = {5'b0, tcr};
            3'd4: rd_data = {scsi_rst, scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io, scsi_sel, 1'b0};
            3'd5: rd_data = {end_dma, drq, 1'b0, irq, phase_match, busy_err, scsi_atn, scsi_ack};
            3'd6: rd_data = dma_data;
            default: rd_data = 8'h00;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ret_tx <= 1'b0;
            odr <= '0;
            icr <= '0;
            mr <= '0;
            tcr <= '0;
            dma_data <= '0;
            bus_dout <= '0;
            drq <= 1'b0;
            irq <= 1'b0;
            dma_ack <= 1'b0;
            end_dma <= 1'b0;
            busy_err <= 1'b0;
        end else begin
            if (rd || drd) bus_dout <= drd ? dma_data : rd_data;
            if (rd && bus_addr == 3'd7) begin
                irq <= 1'b0;
                busy_err <= 1'b0;
                end_dma <= 1'b0;
            end
            if (wr) begin
                case (bus_addr)
                    3'd0: odr <= bus_din;
                    3'd1: icr <= bus_din & 8'h97;
                    3'd2: mr <= bus_din;
                    3'd3: tcr <= bus_din[2:0];
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (wr && mr[1] && bus_addr == 3'd5) begin
                        drq <= 1'b1;
                        state <= TX_WAIT_CPU;
                    end else if (wr && mr[1] && bus_addr == 3'd7) state <= RX_WAIT_REQ;
                end
                RX_WAIT_REQ: if (scsi_req && phase_match) begin
                    dma_data <= scsi_din;
                    drq <= 1'b1;
                    state <= RX_WAIT_CPU;
                end
                RX_WAIT_CPU: if (drd) begin
                    drq <= 1'b0;
                    dma_ack <= 1'b1;
                    ret_tx <= 1'b0;
                    state <= ACK_HI;
                end
                TX_WAIT_CPU: if (dwr) begin
                    odr <= bus_din;
                    dma_data <= bus_din;
                    drq <= 1'b0;
                    state <= TX_WAIT_REQ;
                end
                TX_WAIT_REQ: if (scsi_req && phase_match) begin
                    dma_ack <= 1'b1;
                    ret_tx <= 1'b1;
                    state <= ACK_HI;
                end
                ACK_HI: if (!scsi_req) begin
                    dma_ack <= 1'b0;
                    drq <= ret_tx;
                    state <= ret_tx ? TX_WAIT_CPU : RX_WAIT_REQ;
                end
                default: state <= IDLE;
            endcase
            // A req in the wrong phase ends the transfer without acknowledging it.
            if (wait_req && scsi_req && !phase_match) begin
                end_dma <= 1'b1;
                drq <= 1'b0;
                state <= IDLE;
                if (mr[4]) irq <= 1'b1;
            end
            if (wr && bus_addr == 3'd2 && !bus_din[1]) begin
                state <= IDLE;
                dma_ack <= 1'b0;
                drq <= 1'b0;
            end
            if (busy_lost) begin
                busy_err <= 1'b1;
                mr[1] <= 1'b0;
                dma_ack <= 1'b0;
                drq <= 1'b0;
                state <= IDLE;
                irq <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ncr5380_lite.sv
// tb_ncr5380_lite: randomized bench with a register-level reference model and a
// read-data scoreboard popped by an independent monitor.
module tb_ncr5380_lite;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_cs = 1'b0, bus_we = 1'b0, bus_dack = 1'b0;
    logic [2:0] bus_addr = '0;
    logic [7:0] bus_din = '0;
    logic [7:0] bus_dout;
    logic drq, irq, scsi_rst, scsi_sel, scsi_atn, scsi_ack;
    logic [7:0] scsi_dout;
    logic scsi_bsy = 1'b0, scsi_msg = 1'b0, scsi_cd = 1'b0, scsi_io = 1'b0, scsi_req = 1'b0;
    logic [7:0] scsi_din = '0;

    always #5 clk = ~clk;

    ncr5380_lite dut (
        .clk(clk), .rst(rst), .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_dack(bus_dack), .bus_din(bus_din), .bus_dout(bus_dout), .drq(drq), .irq(irq),
        .scsi_rst(scsi_rst), .scsi_sel(scsi_sel), .scsi_atn(scsi_atn), .scsi_ack(scsi_ack),
        .scsi_dout(scsi_dout), .scsi_bsy(scsi_bsy), .scsi_msg(scsi_msg), .scsi_cd(scsi_cd),
        .scsi_io(scsi_io), .scsi_req(scsi_req), .scsi_din(scsi_din)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] expq[$];
    logic rd_q = 1'b0;

    // Reference model of the programmer-visible state.
    logic [7:0] m_odr, m_icr, m_mr, m_dma;
    logic [2:0] m_tcr;
    logic m_drq, m_ack, m_irq, m_end, m_berr, m_tx;

    always @(posedge clk) rd_q <= !rst && bus_cs && !bus_we;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rd_q) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL readback: got %h with no expected value queued", bus_dout);
            end else begin
                e = expq.pop_front();
                if (bus_dout !== e) begin
                    bad++;
                    $display("FAIL readback: got %h expected %h", bus_dout, e);
                end
            end
        end
    end

    task automatic model_reset;
        {m_odr, m_icr, m_mr, m_dma} = '0;
        m_tcr = '0;
        {m_drq, m_ack, m_irq, m_end, m_berr, m_tx} = '0;
    endtask

    function automatic logic [7:0] m_scsi_dout();
        return (m_icr[0] | m_tx) ? m_odr : 8'h00;
    endfunction

    function automatic logic [7:0] exp_reg(input logic [2:0] a);
        logic pm;
        pm = ({scsi_msg, scsi_cd, scsi_io} == m_tcr);
        case (a)
            3'd0: return scsi_io ? scsi_din : m_scsi_dout();
            3'd1: return m_icr;
            3'd2: return m_mr;
            3'd3: return {5'b0, m_tcr};
            3'd4: return {m_icr[7], scsi_bsy, scsi_req, scsi_msg, scsi_cd, scsi_io, m_icr[2], 1'b0};
            3'd5: return {m_end, m_drq, 1'b0, m_irq, pm, m_berr, m_icr[1], m_icr[4] | m_ack};
            3'd6: return m_dma;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_outs(input string n);
        chk({n, " lines"}, {2'b0, scsi_rst, scsi_sel, scsi_atn, scsi_ack, drq, irq},
            {2'b0, m_icr[7], m_icr[2], m_icr[1], m_icr[4] | m_ack, m_drq, m_irq});
        chk({n, " scsi_dout"}, scsi_dout, m_scsi_dout());
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_din = d;
        tick;
        bus_cs = 1'b0; bus_we = 1'b0;
        case (a)
            3'd0: m_odr = d;
            3'd1: m_icr = d & 8'h97;
            3'd2: begin
                m_mr = d;
                if (!d[1]) begin m_drq = 1'b0; m_ack = 1'b0; m_tx = 1'b0; end
            end
            3'd3: m_tcr = d[2:0];
            default: ;
        endcase
    endtask

    task automatic rd(input logic [2:0] a);
        expq.push_back(exp_reg(a));
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        tick;
        bus_cs = 1'b0;
        if (a == 3'd7) begin m_irq = 1'b0; m_end = 1'b0; m_berr = 1'b0; end
    endtask

    task automatic drd(input logic [7:0] exp);
        expq.push_back(exp);
        bus_cs = 1'b1; bus_we = 1'b0; bus_dack = 1'b1;
        tick;
        bus_cs = 1'b0; bus_dack = 1'b0;
    endtask

    task automatic dwr(input logic [7:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_dack = 1'b1; bus_din = d;
        tick;
        bus_cs = 1'b0; bus_we = 1'b0; bus_dack = 1'b0;
    endtask

    // Target sends one byte; ack must wait for the CPU read and drop right after req.
    task automatic rx_byte(input logic [7:0] b);
        scsi_din = b;
        chk_outs("rx idle");
        scsi_req = 1'b1;
        tick;
        m_dma = b; m_drq = 1'b1;
        chk_outs("rx drq");
        repeat ($urandom_range(0, 2)) begin
            tick;
            chk_outs("rx hold");
        end
        drd(b);
        m_drq = 1'b0; m_ack = 1'b1;
        chk_outs("rx ack");
        scsi_req = 1'b0;
        tick;
        m_ack = 1'b0;
        chk_outs("rx ack drop");
    endtask

    task automatic tx_byte(input logic [7:0] b);
        dwr(b);
        m_odr = b; m_dma = b; m_drq = 1'b0;
        chk_outs("tx loaded");
        repeat ($urandom_range(0, 2)) tick;
        scsi_req = 1'b1;
        tick;
        m_ack = 1'b1;
        chk_outs("tx ack");
        chk("tx capture", scsi_dout, b);
        scsi_req = 1'b0;
        tick;
        m_ack = 1'b0; m_drq = 1'b1;
        chk_outs("tx release");
    endtask

    initial begin
        logic [7:0] b;
        logic [2:0] a;
        model_reset();
        repeat (2) tick;
        rst = 1'b0;
        chk_outs("reset");
        for (int i = 0; i < 8; i++) rd(3'(i));

        wr(3'd0, 8'h01);
        wr(3'd1, 8'h05);
        chk_outs("select");
        scsi_bsy = 1'b1;
        rd(3'd4);
        wr(3'd1, 8'h00);
        chk_outs("release");

        for (int i = 0; i < 16; i++) begin
            a = 3'($urandom_range(0, 3));
            b = 8'($urandom);
            if (a == 3'd2) b = b & 8'h18;
            wr(a, b);
            {scsi_bsy, scsi_msg, scsi_cd, scsi_io, scsi_req} = 5'($urandom);
            scsi_din = 8'($urandom);
            chk_outs("random");
            rd(3'($urandom_range(0, 6)));
        end
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        {scsi_bsy, scsi_msg, scsi_cd, scsi_io, scsi_req} = 5'b10000;

        wr(3'd2, 8'h02);
        wr(3'd3, 8'h01);
        scsi_io = 1'b1;
        wr(3'd7, 8'h00);
        rx_byte(8'hA5);
        rx_byte(8'h5A);
        rx_byte(8'h3C);
        rx_byte(8'($urandom));
        rd(3'd6);
        wr(3'd2, 8'h00);

        wr(3'd3, 8'h00);
        scsi_io = 1'b0;
        wr(3'd2, 8'h02);
        wr(3'd5, 8'h00);
        m_tx = 1'b1; m_drq = 1'b1;
        chk_outs("tx start");
        tx_byte(8'h11);
        tx_byte(8'h22);
        tx_byte(8'($urandom));
        rd(3'd0);
        wr(3'd2, 8'h00);
        chk_outs("tx abort");

        wr(3'd2, 8'h12);
        wr(3'd3, 8'h01);
        scsi_io = 1'b1;
        wr(3'd7, 8'h00);
        rx_byte(8'($urandom));
        scsi_cd = 1'b1;
        scsi_req = 1'b1;
        tick;
        m_end = 1'b1; m_drq = 1'b0; m_irq = m_mr[4];
        chk_outs("mismatch");
        tick;
        chk_outs("mismatch no ack");
        scsi_req = 1'b0;
        rd(3'd5);
        rd(3'd7);
        chk_outs("irq cleared");
        rd(3'd5);
        scsi_cd = 1'b0;

        wr(3'd2, 8'h0A);
        wr(3'd7, 8'h00);
        scsi_din = 8'($urandom);
        scsi_req = 1'b1;
        tick;
        m_dma = scsi_din; m_drq = 1'b1;
        drd(m_dma);
        m_drq = 1'b0; m_ack = 1'b1;
        chk_outs("busy ack");
        scsi_bsy = 1'b0;
        tick;
        m_berr = 1'b1; m_mr[1] = 1'b0; m_ack = 1'b0; m_irq = 1'b1;
        chk_outs("busy loss");
        scsi_req = 1'b0;
        rd(3'd2);
        rd(3'd5);
        rd(3'd7);
        rd(3'd5);
        scsi_bsy = 1'b1;

        wr(3'd0, 8'($urandom));
        wr(3'd1, 8'h93);
        wr(3'd2, 8'h12);
        wr(3'd7, 8'h00);
        scsi_din = 8'($urandom);
        scsi_req = 1'b1;
        tick;
        m_dma = scsi_din; m_drq = 1'b1;
        chk_outs("pre reset");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        chk_outs("mid dma reset");
        scsi_req = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i));

        repeat (3) tick;
        chk("scoreboard drained", 8'(expq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
